period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter_pkg.sv | 12 +
 rtl/flag_edge_det.sv | 22 ++
 rtl/period_meter.sv | 91 +++++++++
 tb/tb_period_meter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding for the period meter.
package period_meter_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } state_t;

endpackage

// File: rtl/flag_edge_det.sv
// flag_edge_det: registered rising-edge detector; pulse is one cycle after the 0->1 sample.
module flag_edge_det (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic level,
    output logic pulse
);

    logic level_prev;

    // Remember the previous level and flag a 0->1 transition one cycle later.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            level_prev <= 1'b0;
            pulse      <= 1'b0;
        end else begin
            level_prev <= level;
            pulse      <= level & ~level_prev;
        end
    end

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the interval between pulses on flag_in in sys_clk cycles.
// Build option PERIOD_METER_EDGE_DETECT_EN: flag_in is treated as a level and only its
// registered rising edges count as pulses, which delays every strobe by one cycle.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned CONTINUOUS = 0
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    input  logic         flag_in,
    input  logic         start,
    output logic [N-1:0] period,
    output logic         period_valid,
    output logic         overflow,
    output logic         busy
);

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};

    state_t       state;
    logic [N-1:0] cnt;
    logic         pulse;

`ifdef PERIOD_METER_EDGE_DETECT_EN
    flag_edge_det u_edge_det (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .level   (flag_in),
        .pulse   (pulse)
    );
`else
    assign pulse = flag_in;
`endif

    // Measurement FSM; all outputs registered, busy tracks the next state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            overflow     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (pulse) begin
                        state <= MEAS;
                        cnt   <= CNT_ONE;
                    end
                end
                MEAS: begin
                    // A closing pulse takes priority over saturation on the same edge.
                    if (pulse) begin
                        period       <= cnt;
                        period_valid <= 1'b1;
                        if (CONTINUOUS != 0) begin
                            cnt <= CNT_ONE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (cnt == CNT_MAX) begin
                        period   <= cnt;
                        overflow <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed scoreboard bench for period_meter (three configurations).
module tb_period_meter;

`ifdef PERIOD_METER_EDGE_DETECT_EN
    localparam int LAT   = 1;
    localparam int EXP_E = 12;
    localparam int OFF_E = 12;
`else
    localparam int LAT   = 0;
    localparam int EXP_E = 1;
    localparam int OFF_E = 1;
`endif

    typedef struct {
        int dut;
        bit ovf;
        int val;
        int edge_at;
    } exp_t;

    logic        sys_clk;
    logic        sys_rst;
    logic        flag_in;
    logic [2:0]  start;

    logic [15:0] period0, period1;
    logic [3:0]  period2;
    logic        pv0, pv1, pv2;
    logic        ov0, ov1, ov2;
    logic        busy0, busy1, busy2;

    exp_t sb[$];
    int   total;
    int   bad;
    int   edge_n;

    period_meter #(.N(16), .CONTINUOUS(0)) u_dut0 (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .flag_in      (flag_in),
        .start        (start[0]),
        .period       (period0),
        .period_valid (pv0),
        .overflow     (ov0),
        .busy         (busy0)
    );

    period_meter #(.N(16), .CONTINUOUS(1)) u_dut1 (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .flag_in      (flag_in),
        .start        (start[1]),
        .period       (period1),
        .period_valid (pv1),
        .overflow     (ov1),
        .busy         (busy1)
    );

    period_meter #(.N(4), .CONTINUOUS(0)) u_dut2 (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .flag_in      (flag_in),
        .start        (start[2]),
        .period       (period2),
        .period_valid (pv2),
        .overflow     (ov2),
        .busy         (busy2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic fail_msg(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else fail_msg(tag, obs, exp_v);
    endtask

    // Expected strobe from the step about to be driven, offset edges later.
    task automatic expect_next(input int d, input bit ovf, input int val, input int offset);
        exp_t e;
        e.dut     = d;
        e.ovf     = ovf;
        e.val     = val;
        e.edge_at = edge_n + 1 + offset;
        sb.push_back(e);
    endtask

    task automatic check_dut(input int d, input logic pv, input logic ov, input logic [15:0] per);
        exp_t e;
        logic strobe;
        bit   head;
        strobe = pv | ov;
        head   = (sb.size() != 0) && (sb[0].dut == d);
        if (head && (sb[0].edge_at <= edge_n)) begin
            total++;
            assert (strobe === 1'b1)
            else fail_msg($sformatf("strobe_missing_d%0d_e%0d", d, edge_n), 32'(strobe), 1);
            if (strobe !== 1'b1) begin
                e = sb.pop_front();
            end
        end
        if (strobe === 1'b1) begin
            total++;
            assert ((pv & ov) === 1'b0)
            else fail_msg($sformatf("strobes_exclusive_d%0d", d), 32'(pv & ov), 0);
            head = (sb.size() != 0) && (sb[0].dut == d);
            total++;
            assert (head)
            else fail_msg($sformatf("unexpected_strobe_d%0d_e%0d", d, edge_n), 32'(strobe), 0);
            if (head) begin
                e = sb.pop_front();
                chk($sformatf("overflow_kind_d%0d", d), 32'(ov), 32'(e.ovf));
                chk($sformatf("period_value_d%0d", d), {16'b0, per}, e.val);
                chk($sformatf("strobe_edge_d%0d", d), edge_n, e.edge_at);
            end
        end
    endtask

    task automatic step(input logic f, input logic [2:0] st);
        flag_in = f;
        start   = st;
        @(posedge sys_clk);
        #1;
        edge_n++;
        check_dut(0, pv0, ov0, period0);
        check_dut(1, pv1, ov1, period1);
        check_dut(2, pv2, ov2, {12'b0, period2});
        flag_in = 1'b0;
        start   = 3'b000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000);
    endtask

    // Short reset entirely between two clock edges.
    task automatic pulse_reset();
        #2 sys_rst = 1'b1;
        #2 sys_rst = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        edge_n  = 0;
        sys_rst = 1'b1;
        flag_in = 1'b0;
        start   = 3'b000;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_period0", {16'b0, period0}, 0);
        chk("rst_valid0", 32'(pv0), 0);
        chk("rst_ovf0", 32'(ov0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_busy1", 32'(busy1), 0);
        chk("rst_period2", {28'b0, period2}, 0);
        chk("rst_busy2", 32'(busy2), 0);
        sys_rst = 1'b0;

        // Single-shot, N=16, pulses every 10; a second start mid-measurement is ignored.
        step(1'b0, 3'b001);
        chk("a_busy_arm", 32'(busy0), 1);
        step(1'b1, 3'b000);
        idle(4);
        step(1'b0, 3'b001);
        idle(4);
        expect_next(0, 1'b0, 10, LAT);
        step(1'b1, 3'b000);
        idle(2);
        chk("a_busy_done", 32'(busy0), 0);
        idle(7);
        step(1'b1, 3'b000);
        idle(5);
        chk("a_period_hold", {16'b0, period0}, 10);

        // Continuous: three intervals of 10 then three of 7, each strobed.
        step(1'b0, 3'b010);
        step(1'b1, 3'b000);
        for (int k = 0; k < 3; k++) begin
            idle(9);
            expect_next(1, 1'b0, 10, LAT);
            step(1'b1, 3'b000);
        end
        for (int k = 0; k < 3; k++) begin
            idle(6);
            expect_next(1, 1'b0, 7, LAT);
            step(1'b1, 3'b000);
        end
        idle(2);
        chk("b_busy_still", 32'(busy1), 1);
        pulse_reset();
        chk("b_busy_after_rst", 32'(busy1), 0);

        // N=4: one pulse, no closing pulse -> overflow with period 15.
        step(1'b0, 3'b100);
        expect_next(2, 1'b1, 15, 15 + LAT);
        step(1'b1, 3'b000);
        idle(20);
        chk("c_busy_idle", 32'(busy2), 0);
        chk("c_period_sat", {28'b0, period2}, 15);

        // N=4: closing pulse exactly on the saturating edge -> valid, no overflow.
        step(1'b0, 3'b100);
        step(1'b1, 3'b000);
        idle(14);
        expect_next(2, 1'b0, 15, LAT);
        step(1'b1, 3'b000);
        idle(3);
        chk("d_busy_idle", 32'(busy2), 0);

        // flag_in high 3 cycles every 12: level mode measures 1, edge mode measures 12.
        step(1'b0, 3'b001);
        expect_next(0, 1'b0, EXP_E, OFF_E + LAT);
        for (int r = 0; r < 2; r++) begin
            step(1'b1, 3'b000);
            step(1'b1, 3'b000);
            step(1'b1, 3'b000);
            idle(9);
        end
        idle(3);
        chk("e_period", {16'b0, period0}, EXP_E);
        chk("e_busy", 32'(busy0), 0);

        // Reset mid-measurement: outputs clear at once, nothing strobes afterwards.
        step(1'b0, 3'b001);
        step(1'b1, 3'b000);
        idle(4);
        chk("f_busy_meas", 32'(busy0), 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("f_rst_busy", 32'(busy0), 0);
        chk("f_rst_period", {16'b0, period0}, 0);
        chk("f_rst_valid", 32'(pv0), 0);
        chk("f_rst_ovf", 32'(ov0), 0);
        #1 sys_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 3'b000);
            idle(4);
        end
        chk("f_busy_no_start", 32'(busy0), 0);

        // Fresh start after reset still works.
        step(1'b0, 3'b001);
        step(1'b1, 3'b000);
        idle(4);
        expect_next(0, 1'b0, 5, LAT);
        step(1'b1, 3'b000);
        idle(4);

        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
